// File: rtl/dff_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: state encoding
// and default sizing.
package dff_reg_arbiter_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned ID_W_DEF  = 2;

    // Code 2'd3 is unused and treated as illegal by the sequencer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_e;

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first set request after last_id_i,
// wrapping modulo N_REQ (valid for non-power-of-2 N_REQ).
module dff_reg_arbiter_rr_pick
    import dff_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_id_i,
    output logic [ID_W-1:0]  winner_o,
    output logic             found_o
);

    logic [ID_W:0] cand;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        cand     = '0;
        // One extra bit holds last_id + offset (at most 2*N_REQ-1) before the wrap.
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = {1'b0, last_id_i} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!found_o && req_i[cand[ID_W-1:0]]) begin
                winner_o = cand[ID_W-1:0];
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register; grants one
// requester, captures its data slice, then pulses ack/q_valid for one cycle.
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [ID_W-1:0]        last_id,
    output logic                   busy
);

    state_e             state_q;
    logic [ID_W-1:0]    win_q;
    logic [ID_W-1:0]    last_id_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   ack_q;
    logic               q_valid_q;
    logic [WIDTH-1:0]   q_q;

    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    logic               load_en;
    logic [WIDTH-1:0]   slices [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slices[i] = wdata[i*WIDTH +: WIDTH];
    end

    dff_reg_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i     (req),
        .last_id_i (last_id_q),
        .winner_o  (pick_id),
        .found_o   (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            q_valid_q <= 1'b0;
            last_id_q <= ID_W'(N_REQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        win_q   <= pick_id;
                        gnt_q   <= onehot(pick_id);
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A winner that dropped its request before the write aborts silently.
                    if (req[win_q]) begin
                        ack_q     <= onehot(win_q);
                        q_valid_q <= 1'b1;
                        state_q   <= S_ACK;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_ACK: begin
                    ack_q     <= '0;
                    q_valid_q <= 1'b0;
                    gnt_q     <= '0;
                    last_id_q <= win_q;
                    state_q   <= S_IDLE;
                end
                default: begin
                    ack_q     <= '0;
                    q_valid_q <= 1'b0;
                    gnt_q     <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign load_en = (state_q == S_GRANT) && req[win_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else if (load_en) begin
            q_q <= slices[win_q];
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign last_id = last_id_q;
    assign busy    = (state_q != S_IDLE);

    gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    ack_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
    ack_in_gnt_a: assert property (@(posedge clk) disable iff (reset) (|ack) |-> (ack == gnt));

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter: directed scenarios plus a random
// run checked against a transaction-level round-robin model.
module tb_dff_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]  gnt, ack;
    logic [W-1:0]  q;
    logic          q_valid, busy;
    logic [1:0]    last_id;

    logic [2:0]    req3;
    logic [3*W-1:0] wdata3;
    logic [2:0]    gnt3, ack3;
    logic [W-1:0]  q3;
    logic          q_valid3, busy3;
    logic [1:0]    last_id3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current winner (-1 none), phase since grant, last writer.
    int         m_win, m_phase, m_last;
    logic [W-1:0] m_q;

    logic [N-1:0] exp_gnt, exp_ack;

    dff_reg_arbiter #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .q_valid (q_valid),
        .last_id (last_id),
        .busy    (busy)
    );

    dff_reg_arbiter #(.N_REQ(3), .WIDTH(8), .ID_W(2)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .req     (req3),
        .wdata   (wdata3),
        .gnt     (gnt3),
        .ack     (ack3),
        .q       (q3),
        .q_valid (q_valid3),
        .last_id (last_id3),
        .busy    (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_search(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_win = -1; m_phase = 0; m_last = N - 1; m_q = '0;
    endfunction

    function automatic void model_step();
        int w;
        if (m_phase == 0) begin
            w = rr_search(req, m_last);
            if (w >= 0) begin m_win = w; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (req[m_win]) begin m_q = wdata[m_win*W +: W]; m_phase = 2; end
            else begin m_win = -1; m_phase = 0; end
        end else begin
            m_last = m_win; m_win = -1; m_phase = 0;
        end
        exp_gnt = (m_win >= 0) ? N'(1 << m_win) : '0;
        exp_ack = (m_phase == 2) ? N'(1 << m_win) : '0;
    endfunction

    // Advance one clock; outputs are settled when this returns.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
        req = '0; req3 = '0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_tests++; if (busy !== 1'b0 || q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_busy_qv got=%b%b exp=00", busy, q_valid); end
        n_tests++; if (last_id !== 2'd3) begin n_fail++; $display("FAIL reset_last_id got=%0d exp=3", last_id); end
        n_tests++; if (last_id3 !== 2'd2) begin n_fail++; $display("FAIL reset_last_id3 got=%0d exp=2", last_id3); end
        @(posedge clk); #1;
        reset = 1'b0;
        req = 4'b0001; wdata[0 +: W] = 8'h77;
        tick(); tick();
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_pre_gnt got=%b exp=0010", gnt); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++; if (gnt !== 4'b0000 || ack !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt_ack got=%b/%b exp=0000/0000", gnt, ack); end
        n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL midrst_q got=%h exp=00", q); end
        n_tests++; if (busy !== 1'b0 || last_id !== 2'd3) begin n_fail++; $display("FAIL midrst_busy_last got=%b/%0d exp=0/3", busy, last_id); end
        #1;
        reset = 1'b0;
        req = 4'b1111;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_gnt got=%b exp=0001", gnt); end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_basic();
        req = 4'b0001; wdata[0 +: W] = 8'hA5;
        tick();
        n_tests++; if (gnt !== 4'b0001 || busy !== 1'b1 || ack !== 4'b0000) begin n_fail++; $display("FAIL basic_grant got=%b/%b/%b exp=0001/1/0000", gnt, busy, ack); end
        tick();
        n_tests++; if (q !== 8'hA5) begin n_fail++; $display("FAIL basic_q got=%h exp=a5", q); end
        n_tests++; if (ack !== 4'b0001 || q_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ack got=%b/%b exp=0001/1", ack, q_valid); end
        req = 4'b0000;
        tick();
        n_tests++; if (busy !== 1'b0 || last_id !== 2'd0 || ack !== 4'b0000 || q_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_done got=%b/%0d/%b/%b exp=0/0/0000/0", busy, last_id, ack, q_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        pulse_reset();
        wdata = {8'h40, 8'h30, 8'h20, 8'h10};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            eg = N'(1 << (k % N));
            ed = 8'(8'h10 * ((k % N) + 1));
            tick();
            n_tests++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, eg); end
            tick();
            n_tests++; if (q !== ed || ack !== eg) begin n_fail++; $display("FAIL rr_write k=%0d got=%h/%b exp=%h/%b", k, q, ack, ed, eg); end
            tick();
            n_tests++; if (busy !== 1'b0 || last_id !== 2'(k % N)) begin n_fail++; $display("FAIL rr_idle k=%0d got=%b/%0d exp=0/%0d", k, busy, last_id, k % N); end
        end
    endtask

    task automatic test_abort();
        req = 4'b0010; wdata[1*W +: W] = 8'h11;
        tick(); tick();
        req = 4'b0000;
        tick();
        n_tests++; if (last_id !== 2'd1) begin n_fail++; $display("FAIL abort_setup got=%0d exp=1", last_id); end
        req = 4'b0100; wdata[2*W +: W] = 8'h22;
        tick();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_gnt got=%b exp=0100", gnt); end
        req = 4'b0000;
        tick();
        n_tests++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || q_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_clear got=%b/%b/%b/%b exp=0000/0000/0/0", gnt, ack, busy, q_valid);
        end
        n_tests++; if (q !== 8'h11 || last_id !== 2'd1) begin n_fail++; $display("FAIL abort_hold got=%h/%0d exp=11/1", q, last_id); end
        req = 4'b0100;
        tick();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_regnt got=%b exp=0100", gnt); end
        tick();
        n_tests++; if (q !== 8'h22 || ack !== 4'b0100) begin n_fail++; $display("FAIL abort_rewrite got=%h/%b exp=22/0100", q, ack); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        req = 4'b1000; wdata[3*W +: W] = 8'h33;
        tick(); tick();
        req = 4'b0000;
        tick();
        n_tests++; if (last_id !== 2'd3) begin n_fail++; $display("FAIL wrap_setup got=%0d exp=3", last_id); end
        req = 4'b1001; wdata[0 +: W] = 8'h01; wdata[3*W +: W] = 8'h03;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0 got=%b exp=0001", gnt); end
        tick(); tick();
        n_tests++; if (last_id !== 2'd0) begin n_fail++; $display("FAIL wrap_last0 got=%0d exp=0", last_id); end
        tick();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt3 got=%b exp=1000", gnt); end
        tick();
        n_tests++; if (q !== 8'h03) begin n_fail++; $display("FAIL wrap_q3 got=%h exp=03", q); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_isolation();
        req = 4'b0010; wdata[1*W +: W] = 8'h5A; wdata[2*W +: W] = 8'($urandom);
        tick();
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL iso_gnt got=%b exp=0010", gnt); end
        req = 4'b1010; wdata[2*W +: W] = ~wdata[2*W +: W];
        tick();
        n_tests++; if (q !== 8'h5A || ack !== 4'b0010) begin n_fail++; $display("FAIL iso_write got=%h/%b exp=5a/0010", q, ack); end
        req = 4'b0000; wdata[2*W +: W] = ~wdata[2*W +: W];
        tick();
        n_tests++; if (q !== 8'h5A || ack !== 4'b0000 || last_id !== 2'd1) begin
            n_fail++; $display("FAIL iso_after got=%h/%b/%0d exp=5a/0000/1", q, ack, last_id);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            n_tests++;
            if (gnt !== exp_gnt || ack !== exp_ack || q !== m_q || q_valid !== (m_phase == 2)
                || busy !== (m_win >= 0) || last_id !== 2'(m_last)) begin
                n_fail++; errs++;
                if (errs <= 10) $display("FAIL random cyc=%0d got gnt=%b ack=%b q=%h qv=%b busy=%b last=%0d exp gnt=%b ack=%b q=%h qv=%b busy=%b last=%0d",
                    cyc, gnt, ack, q, q_valid, busy, last_id, exp_gnt, exp_ack, m_q, m_phase == 2, m_win >= 0, m_last);
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (exp_ack[i]) begin
                        if ($urandom_range(3) == 0) wdata[i*W +: W] = 8'($urandom);
                        else req[i] = 1'b0;
                    end else if ($urandom_range(19) == 0) begin
                        req[i] = 1'b0;
                    end
                end else begin
                    wdata[i*W +: W] = 8'($urandom);
                    if ($urandom_range(2) == 0) req[i] = 1'b1;
                end
            end
        end
        req = '0;
    endtask

    task automatic test_wrap3();
        pulse_reset();
        wdata3 = {8'h33, 8'h32, 8'h31};
        req3 = 3'b110;
        tick();
        n_tests++; if (gnt3 !== 3'b010) begin n_fail++; $display("FAIL n3_gnt_a got=%b exp=010", gnt3); end
        tick();
        n_tests++; if (q3 !== 8'h32 || ack3 !== 3'b010) begin n_fail++; $display("FAIL n3_write_a got=%h/%b exp=32/010", q3, ack3); end
        req3 = 3'b000;
        tick();
        req3 = 3'b101;
        tick();
        n_tests++; if (gnt3 !== 3'b100) begin n_fail++; $display("FAIL n3_gnt_b got=%b exp=100", gnt3); end
        tick();
        req3 = 3'b000;
        tick();
        n_tests++; if (last_id3 !== 2'd2 || q3 !== 8'h33) begin n_fail++; $display("FAIL n3_last_b got=%0d/%h exp=2/33", last_id3, q3); end
        req3 = 3'b011;
        tick();
        n_tests++; if (gnt3 !== 3'b001) begin n_fail++; $display("FAIL n3_gnt_c got=%b exp=001", gnt3); end
        tick();
        req3 = 3'b000;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        wdata  = '0;
        req3   = '0;
        wdata3 = '0;
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_abort();
        test_wrap();
        test_isolation();
        test_random();
        test_wrap3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
